// File: rtl/signed_accumulator.sv
// Signed running accumulator behind a valid/ready command port (load/add/clear).
// Define ACC_SATURATE_EN to saturate on add overflow instead of wrapping.
module signed_accumulator #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_cmd,
    input  logic [W-1:0]     d_in,
    input  logic             ovfl_in,
    output logic [W-1:0]     acc,
    output logic             err,
    output logic             res_valid,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_ADD   = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    state_t           r_state;
    cmd_t             r_cmd;
    logic [W-1:0]     r_d;
    logic             r_ovfl;
    logic [W-1:0]     r_acc;
    logic             r_err;
    logic             r_res_valid;
    logic             r_op_ready;
    logic [CNT_W-1:0] r_count;

    logic [W-1:0]     w_sum;
    logic             w_ovf;
    logic [W-1:0]     w_add_result;

    // Signed overflow: like-signed operands producing a differently-signed sum.
    always_comb begin
        w_sum        = r_acc + r_d;
        w_ovf        = (r_acc[W-1] == r_d[W-1]) && (w_sum[W-1] != r_acc[W-1]);
        w_add_result = w_sum;
`ifdef ACC_SATURATE_EN
        if (w_ovf) begin
            w_add_result = r_acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd       <= CMD_LOAD;
            r_d         <= '0;
            r_ovfl      <= 1'b0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_op_ready  <= 1'b1;
            r_count     <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // op_ready is high throughout IDLE, so op_valid alone marks a transfer.
                    if (op_valid) begin
                        r_cmd      <= cmd_t'(op_cmd);
                        r_d        <= d_in;
                        r_ovfl     <= ovfl_in;
                        r_op_ready <= 1'b0;
                        r_state    <= EXEC;
                        if (r_count != '1) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    case (r_cmd)
                        CMD_LOAD: begin
                            r_acc <= r_d;
                            r_err <= r_ovfl;
                        end
                        CMD_ADD: begin
                            if (r_ovfl) begin
                                r_err <= 1'b1;
                            end else begin
                                r_acc <= w_add_result;
                                r_err <= r_err | w_ovf;
                            end
                        end
                        CMD_CLEAR: begin
                            r_acc <= '0;
                            r_err <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_op_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_op_ready <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign op_ready  = r_op_ready;
    assign acc       = r_acc;
    assign err       = r_err;
    assign res_valid = r_res_valid;
    assign op_count  = r_count;

endmodule

// File: doc/signed_accumulator.md
Name: signed_accumulator

Overview:
- Downstream consumer of sign_changer: takes its 8-bit two's-complement result d and overflow flag ovfl and folds them into a running signed total.
- Commands are load, add and clear, accepted over a valid/ready handshake.
- Outputs go to the display and LED stage: the registered total, a sticky error flag, a result strobe and an accepted-operation count.

Parameters:
- W, 8, operand and accumulator width in bits (two's complement).
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  an operand/command is presented.
- op_ready  output  1  block can accept an operand this cycle.
- op_cmd  input  2  00 = load, 01 = add, 10 = clear, 11 = reserved (treated as no-op).
- d_in  input  W  operand, taken from sign_changer d.
- ovfl_in  input  1  operand invalid, taken from sign_changer ovfl.
- acc  output  W  registered running total.
- err  output  1  sticky error flag.
- res_valid  output  1  one-cycle pulse when acc or err has been updated.
- op_count  output  CNT_W  number of accepted operations; saturates.

Behaviour:
- Reset (async, immediate):
  - acc=0, err=0, res_valid=0, op_count=0.
  - op_ready=1, state=IDLE, capture registers cleared.
  - Reset asserted mid-operation discards the operation in flight; no res_valid is produced for it.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: op_ready=1. On op_valid&op_ready, capture op_cmd, d_in and ovfl_in, then go to EXEC.
  - EXEC: op_ready=0. Compute and register acc/err per the rules below, then go to DONE.
  - DONE: op_ready=0. res_valid=1 for exactly this cycle, then go to IDLE.
- Latency and throughput:
  - Accept at edge N, acc/err valid after edge N+1, res_valid high during cycle N+2.
  - One operation per 3 cycles maximum.
- Handshake:
  - Transfer occurs only when op_valid and op_ready are both high at an edge.
  - op_valid held high while op_ready=0 is ignored. The same operand is taken again on return to IDLE if the upstream is still holding it; the upstream drops op_valid after transfer.
- Load: acc=d_in; err=ovfl_in.
- Clear: acc=0; err=0. d_in and ovfl_in are ignored.
- Add:
  - Sum = acc + d_in, W bits, wrap-around.
  - Signed overflow = operands share a sign and the result sign differs. On overflow, err is set.
  - ovfl_in=1 on an add also sets err.
  - err is sticky: only load or clear can lower it.
  - When ovfl_in=1, acc is left unchanged. The invalid operand is not added.
- Reserved cmd 11: accepted and counted, acc/err unchanged, res_valid still pulses.
- op_count:
  - Increments by 1 at each accepted transfer.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset, not by the clear command.
- All outputs registered; no combinational path from inputs to outputs except none (op_ready is state-decoded).

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on add overflow, acc saturates instead of wrapping.
  - Positive overflow gives 0x7F.
  - Negative overflow gives 0x80.
  - err is still set.
- Undefined: two's-complement wrap as specified above.

Test Plan:
- Reset mid-EXEC (load 0x05 accepted, reset pulsed the next cycle) -> acc=0x00, err=0, op_count=0, no res_valid pulse, op_ready=1 immediately.
- Load 0x05, then add 0xFD (-3) -> acc=0x05, then acc=0x02, err=0. Each res_valid pulse appears 2 cycles after accept. op_count=2.
- Load 0x7F, add 0x01:
  - Without ACC_SATURATE_EN -> acc=0x80, err=1.
  - With ACC_SATURATE_EN -> acc=0x7F, err=1.
  - Follow with add 0x01 -> err stays 1.
- Load 0x10, then add d_in=0x80 with ovfl_in=1 -> acc stays 0x10, err=1. Then clear -> acc=0x00, err=0.
- op_valid held high continuously with cmd=add, d_in=0x01 from acc=0 for 12 cycles -> exactly 4 accepts, op_ready pattern 1,0,0 repeating, acc=0x04.
- 260 back-to-back reserved (11) commands -> op_count saturates at 0xFF, acc unchanged, 260 res_valid pulses.
